// File: rtl/full_adder_pkg.sv
// full_adder_pkg: shared helpers for the full_adder datapath leaf.
// Holds the 3-input majority used as the carry function of each adder cell.
// No ports; imported by full_adder_cell and full_adder.
package full_adder_pkg;

  // Carry out of a single full-adder cell: true when at least two inputs are set.
  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/full_adder_cell.sv
// full_adder_cell: one-bit combinational full adder (sum and majority carry).
// Ports: a, b   - operand bits
//        cin    - carry in;  s - sum bit;  cout - carry out
module full_adder_cell
  import full_adder_pkg::*;
(
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = maj3(a, b, cin);

endmodule

// File: rtl/full_adder.sv
// full_adder: WIDTH-bit unsigned ripple-carry adder, combinational S/Cout plus a
// one-cycle registered copy (S_r/Cout_r/valid_r), synchronous active-high reset.
// Ports: clk, rst; A, B, Cin in; S, Cout combinational; S_r, Cout_r, valid_r registered.
module full_adder
  import full_adder_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic [WIDTH-1:0] S,
  output logic             Cout,
  output logic [WIDTH-1:0] S_r,
  output logic             Cout_r,
  output logic             valid_r
);

  // w_carry[i] is the carry into bit i; w_carry[WIDTH] leaves the MSB.
  logic [WIDTH:0]   w_carry;
  logic [WIDTH-1:0] w_sum;

  logic [WIDTH-1:0] r_sum;
  logic             r_cout;
  logic             r_valid;

  assign w_carry[0] = Cin;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    full_adder_cell u_cell (
      .a    (A[i]),
      .b    (B[i]),
      .cin  (w_carry[i]),
      .s    (w_sum[i]),
      .cout (w_carry[i+1])
    );
  end

  assign S    = w_sum;
  assign Cout = w_carry[WIDTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sum   <= '0;
      r_cout  <= 1'b0;
      r_valid <= 1'b0;
    end else begin
      r_sum   <= w_sum;
      r_cout  <= w_carry[WIDTH];
      r_valid <= 1'b1;
    end
  end

  assign S_r     = r_sum;
  assign Cout_r  = r_cout;
  assign valid_r = r_valid;

endmodule

// File: tb/tb_full_adder.sv
// tb_full_adder: checks full_adder at WIDTH 1, 8 and 16 against bench-computed sums.
module tb_full_adder;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // WIDTH=1 instance
  logic [0:0] a1, b1, s1, s1_r;
  logic       c1, co1, co1_r, v1;
  // WIDTH=8 instance
  logic [7:0] a8, b8, s8, s8_r;
  logic       c8, co8, co8_r, v8;
  // WIDTH=16 instance
  logic [15:0] a16, b16, s16, s16_r;
  logic        c16, co16, co16_r, v16;

  full_adder #(.WIDTH(1)) u_w1 (
    .clk(clk), .rst(rst), .A(a1), .B(b1), .Cin(c1),
    .S(s1), .Cout(co1), .S_r(s1_r), .Cout_r(co1_r), .valid_r(v1)
  );
  full_adder #(.WIDTH(8)) u_w8 (
    .clk(clk), .rst(rst), .A(a8), .B(b8), .Cin(c8),
    .S(s8), .Cout(co8), .S_r(s8_r), .Cout_r(co8_r), .valid_r(v8)
  );
  full_adder #(.WIDTH(16)) u_w16 (
    .clk(clk), .rst(rst), .A(a16), .B(b16), .Cin(c16),
    .S(s16), .Cout(co16), .S_r(s16_r), .Cout_r(co16_r), .valid_r(v16)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic       a;
    logic       b;
    logic       cin;
    logic       s;
    logic       cout;
  } vec1_t;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [7:0] s;
    logic       cout;
  } vec8_t;

  vec1_t       tab1[8];
  vec8_t       tab8[3];
  logic [1:0]  q1[$];   // {Cout,S} expected from the WIDTH=1 register
  logic [16:0] q16[$];  // {Cout,S} expected from the WIDTH=16 register

  initial begin
    logic [1:0]  e1;
    logic [16:0] e16;

    // Truth table, index = {A,B,Cin}
    tab1[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tab1[1] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    tab1[2] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    tab1[3] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    tab1[4] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    tab1[5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    tab1[6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    tab1[7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1};

    tab8[0] = '{8'hFF, 8'h00, 1'b1, 8'h00, 1'b1};
    tab8[1] = '{8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0};
    tab8[2] = '{8'h80, 8'h80, 1'b1, 8'h01, 1'b1};

    a1 = '0; b1 = '0; c1 = 1'b0;
    a8 = '0; b8 = '0; c8 = 1'b0;
    a16 = '0; b16 = '0; c16 = 1'b0;

    // Reset state
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_s1_r", 64'(s1_r), 64'd0);
    check("rst_cout1_r", 64'(co1_r), 64'd0);
    check("rst_valid1", 64'(v1), 64'd0);
    check("rst_s16_r", 64'(s16_r), 64'd0);
    check("rst_valid16", 64'(v16), 64'd0);

    // WIDTH=1 truth table, combinational then registered via the scoreboard
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      a1 = tab1[i].a; b1 = tab1[i].b; c1 = tab1[i].cin;
      #2;
      check($sformatf("tt%0d_S", i), 64'(s1), 64'(tab1[i].s));
      check($sformatf("tt%0d_Cout", i), 64'(co1), 64'(tab1[i].cout));
      q1.push_back({tab1[i].cout, tab1[i].s});
      @(posedge clk);
      #1;
      e1 = q1.pop_front();
      check($sformatf("tt%0d_S_r", i), 64'(s1_r), 64'(e1[0]));
      check($sformatf("tt%0d_Cout_r", i), 64'(co1_r), 64'(e1[1]));
      check($sformatf("tt%0d_valid_r", i), 64'(v1), 64'd1);
    end

    // Reset mid-operation clears the register while S stays combinational
    a1 = 1'b1; b1 = 1'b0; c1 = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("midrst_S_r", 64'(s1_r), 64'd0);
    check("midrst_Cout_r", 64'(co1_r), 64'd0);
    check("midrst_valid_r", 64'(v1), 64'd0);
    check("midrst_S_comb", 64'(s1), 64'd1);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("postrst_S_r", 64'(s1_r), 64'd1);
    check("postrst_valid_r", 64'(v1), 64'd1);

    // WIDTH=8 ripple and general sums
    for (int i = 0; i < 3; i++) begin
      a8 = tab8[i].a; b8 = tab8[i].b; c8 = tab8[i].cin;
      #2;
      check($sformatf("w8_%0d_S", i), 64'(s8), 64'(tab8[i].s));
      check($sformatf("w8_%0d_Cout", i), 64'(co8), 64'(tab8[i].cout));
    end

    // WIDTH=16 random: combinational sum every cycle, register one cycle later
    for (int n = 0; n < 1000; n++) begin
      @(posedge clk);
      #1;
      if (q16.size() > 0) begin
        e16 = q16.pop_front();
        check($sformatf("r%0d_S_r", n), 64'(s16_r), 64'(e16[15:0]));
        check($sformatf("r%0d_Cout_r", n), 64'(co16_r), 64'(e16[16]));
      end
      a16 = 16'($urandom);
      b16 = 16'($urandom);
      c16 = 1'($urandom);
      e16 = 17'(a16) + 17'(b16) + 17'(c16);
      #1;
      check($sformatf("r%0d_sum", n), 64'({co16, s16}), 64'(e16));
      q16.push_back(e16);
    end
    @(posedge clk);
    #1;
    e16 = q16.pop_front();
    check("rlast_S_r", 64'({co16_r, s16_r}), 64'(e16));
    check("rlast_valid_r", 64'(v16), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
